// File: rtl/gpu_pkg.sv
// gpu_pkg: shared core pipeline, LSU state and register-file constants
package gpu_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_COUNT  = 16;
    localparam int REG_ADDR_W = 4;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_e;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/lsu.sv
// lsu: per-thread load/store unit with registered memory handshake and access timeout
module lsu
    import gpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] core_state,
    input  logic       mem_read_enable,
    input  logic       mem_write_enable,
    input  logic [7:0] rs_data,
    input  logic [7:0] rt_data,
    output logic       mem_read_valid,
    output logic [7:0] mem_read_address,
    input  logic       mem_read_ready,
    input  logic [7:0] mem_read_data,
    output logic       mem_write_valid,
    output logic [7:0] mem_write_address,
    output logic [7:0] mem_write_data,
    input  logic       mem_write_ready,
    output logic [1:0] lsu_state,
    output logic [7:0] lsu_out,
    output logic       lsu_error
);

    localparam logic [4:0] CNT_LIMIT = 5'(TIMEOUT_CYCLES - 1);

    lsu_state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       wr_q, wr_d;
    logic       rvalid_q, rvalid_d;
    logic       wvalid_q, wvalid_d;
    logic [7:0] raddr_q, raddr_d;
    logic [7:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] out_q, out_d;
    logic       err_q, err_d;
    logic       act_ready;

    // Only the ready of the access type in flight can complete it
    assign act_ready = wr_q ? mem_write_ready : mem_read_ready;

    // Next-state and output-register logic for the access FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        rvalid_d = rvalid_q;
        wvalid_d = wvalid_q;
        raddr_d  = raddr_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        out_d    = out_q;
        err_d    = err_q;
        case (state_q)
            LSU_IDLE: begin
                if (core_state == CORE_REQUEST && (mem_read_enable || mem_write_enable)) begin
                    state_d = LSU_REQUESTING;
                    wr_d    = !mem_read_enable;
                    err_d   = 1'b0;
                end
            end
            LSU_REQUESTING: begin
                state_d = LSU_WAITING;
                cnt_d   = 5'd0;
                if (wr_q) begin
                    waddr_d  = rs_data;
                    wdata_d  = rt_data;
                    wvalid_d = 1'b1;
                end else begin
                    raddr_d  = rs_data;
                    rvalid_d = 1'b1;
                end
            end
            LSU_WAITING: begin
                if (act_ready) begin
                    state_d  = LSU_DONE;
                    rvalid_d = 1'b0;
                    wvalid_d = 1'b0;
                    out_d    = wr_q ? out_q : mem_read_data;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d  = LSU_DONE;
                    rvalid_d = 1'b0;
                    wvalid_d = 1'b0;
                    out_d    = wr_q ? out_q : 8'hFF;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = (cnt_q == 5'h1F) ? cnt_q : cnt_q + 5'd1;
                end
            end
            default: begin
                if (core_state == CORE_UPDATE) state_d = LSU_IDLE;
            end
        endcase
    end

    // State registers: reset overrides enable, enable=0 freezes everything
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= LSU_IDLE;
            cnt_q    <= 5'd0;
            wr_q     <= 1'b0;
            rvalid_q <= 1'b0;
            wvalid_q <= 1'b0;
            raddr_q  <= 8'h00;
            waddr_q  <= 8'h00;
            wdata_q  <= 8'h00;
            out_q    <= 8'h00;
            err_q    <= 1'b0;
        end else if (enable) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rvalid_q <= rvalid_d;
            wvalid_q <= wvalid_d;
            raddr_q  <= raddr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    assign mem_read_valid    = rvalid_q;
    assign mem_read_address  = raddr_q;
    assign mem_write_valid   = wvalid_q;
    assign mem_write_address = waddr_q;
    assign mem_write_data    = wdata_q;
    assign lsu_state         = state_q;
    assign lsu_out           = out_q;
    assign lsu_error         = err_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for the load/store unit
module tb_lsu;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       mem_read_enable, mem_write_enable;
    logic [7:0] rs_data, rt_data;
    logic       mem_read_valid, mem_write_valid;
    logic [7:0] mem_read_address, mem_write_address, mem_write_data;
    logic       mem_read_ready, mem_write_ready;
    logic [7:0] mem_read_data;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       lsu_error;

    int checks = 0;
    int errors = 0;

    lsu #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .core_state(core_state),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .rs_data(rs_data), .rt_data(rt_data),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        core_state       = 3'b000;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_read_ready   = 1'b0;
        mem_write_ready  = 1'b0;
    endtask

    task automatic start_access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        core_state       = 3'b011;
        mem_read_enable  = rd;
        mem_write_enable = wr;
        rs_data          = a;
        rt_data          = d;
        step();
        step();
        core_state = 3'b100;
    endtask

    task automatic release_done();
        core_state = 3'b110;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        enable = 1'b0;
        reset  = 1'b0;
        idle_inputs();
        rs_data = 8'h00; rt_data = 8'h00; mem_read_data = 8'h00;
        step();
        step();
        checks++;
        if ({lsu_state, mem_read_valid, mem_write_valid, lsu_error} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {lsu_state, mem_read_valid, mem_write_valid, lsu_error});
        end
        checks++;
        if ({mem_read_address, mem_write_address, mem_write_data, lsu_out} !== 32'h0) begin
            errors++; $display("FAIL reset_data got %h want 00000000", {mem_read_address, mem_write_address, mem_write_data, lsu_out});
        end
        reset  = 1'b1;
        enable = 1'b1;
        mem_read_ready = 1'b1;
        step();
        checks++;
        if (lsu_state !== 2'b00 || lsu_out !== 8'h00) begin
            errors++; $display("FAIL idle_stray_ready state %b out %h want 00 00", lsu_state, lsu_out);
        end
        idle_inputs();
    endtask

    task automatic test_read();
        core_state = 3'b011; mem_read_enable = 1'b1; rs_data = 8'h2A;
        step();
        checks++;
        if (lsu_state !== 2'b01 || mem_read_valid !== 1'b0) begin
            errors++; $display("FAIL read_requesting state %b valid %b want 01 0", lsu_state, mem_read_valid);
        end
        step();
        core_state = 3'b100;
        checks++;
        if (lsu_state !== 2'b10 || mem_read_valid !== 1'b1 || mem_read_address !== 8'h2A) begin
            errors++; $display("FAIL read_issue state %b valid %b addr %h want 10 1 2a", lsu_state, mem_read_valid, mem_read_address);
        end
        repeat (3) step();
        checks++;
        if (lsu_state !== 2'b10 || mem_read_valid !== 1'b1) begin
            errors++; $display("FAIL read_wait state %b valid %b want 10 1", lsu_state, mem_read_valid);
        end
        mem_read_ready = 1'b1; mem_read_data = 8'h5C;
        step();
        mem_read_ready = 1'b0;
        checks++;
        if (lsu_state !== 2'b11 || mem_read_valid !== 1'b0 || lsu_out !== 8'h5C || lsu_error !== 1'b0) begin
            errors++; $display("FAIL read_done state %b valid %b out %h err %b want 11 0 5c 0", lsu_state, mem_read_valid, lsu_out, lsu_error);
        end
        core_state = 3'b101;
        step();
        checks++;
        if (lsu_state !== 2'b11) begin
            errors++; $display("FAIL done_hold state %b want 11", lsu_state);
        end
        release_done();
        checks++;
        if (lsu_state !== 2'b00 || mem_read_address !== 8'h2A || lsu_out !== 8'h5C) begin
            errors++; $display("FAIL read_idle state %b addr %h out %h want 00 2a 5c", lsu_state, mem_read_address, lsu_out);
        end
    endtask

    task automatic test_write();
        start_access(1'b0, 1'b1, 8'h10, 8'h77);
        checks++;
        if (mem_write_valid !== 1'b1 || mem_read_valid !== 1'b0 || mem_write_address !== 8'h10 || mem_write_data !== 8'h77) begin
            errors++; $display("FAIL write_issue wv %b rv %b addr %h data %h want 1 0 10 77", mem_write_valid, mem_read_valid, mem_write_address, mem_write_data);
        end
        mem_read_ready = 1'b1;
        step();
        mem_read_ready = 1'b0;
        checks++;
        if (lsu_state !== 2'b10 || mem_write_valid !== 1'b1) begin
            errors++; $display("FAIL write_stray_read_ready state %b wv %b want 10 1", lsu_state, mem_write_valid);
        end
        mem_write_ready = 1'b1;
        step();
        mem_write_ready = 1'b0;
        checks++;
        if (lsu_state !== 2'b11 || mem_write_valid !== 1'b0 || lsu_out !== 8'h5C) begin
            errors++; $display("FAIL write_done state %b wv %b out %h want 11 0 5c", lsu_state, mem_write_valid, lsu_out);
        end
        release_done();
    endtask

    task automatic test_timeout();
        start_access(1'b1, 1'b0, 8'h33, 8'h00);
        repeat (15) step();
        checks++;
        if (lsu_state !== 2'b10 || mem_read_valid !== 1'b1 || lsu_error !== 1'b0) begin
            errors++; $display("FAIL timeout_early state %b valid %b err %b want 10 1 0", lsu_state, mem_read_valid, lsu_error);
        end
        step();
        checks++;
        if (lsu_state !== 2'b11 || mem_read_valid !== 1'b0 || lsu_out !== 8'hFF || lsu_error !== 1'b1) begin
            errors++; $display("FAIL timeout_abort state %b valid %b out %h err %b want 11 0 ff 1", lsu_state, mem_read_valid, lsu_out, lsu_error);
        end
        release_done();
        checks++;
        if (lsu_state !== 2'b00 || lsu_error !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky state %b err %b want 00 1", lsu_state, lsu_error);
        end
        core_state = 3'b011; mem_read_enable = 1'b1; rs_data = 8'h44;
        step();
        checks++;
        if (lsu_state !== 2'b01 || lsu_error !== 1'b0) begin
            errors++; $display("FAIL error_clear state %b err %b want 01 0", lsu_state, lsu_error);
        end
        step();
        core_state = 3'b100;
        repeat (15) step();
        mem_read_ready = 1'b1; mem_read_data = 8'h9E;
        step();
        mem_read_ready = 1'b0;
        checks++;
        if (lsu_state !== 2'b11 || lsu_out !== 8'h9E || lsu_error !== 1'b0) begin
            errors++; $display("FAIL ready_wins_limit state %b out %h err %b want 11 9e 0", lsu_state, lsu_out, lsu_error);
        end
        release_done();
    endtask

    task automatic test_priority();
        start_access(1'b1, 1'b1, 8'h55, 8'hAB);
        checks++;
        if (mem_read_valid !== 1'b1 || mem_write_valid !== 1'b0 || mem_read_address !== 8'h55 || mem_write_address !== 8'h10) begin
            errors++; $display("FAIL priority rv %b wv %b raddr %h waddr %h want 1 0 55 10", mem_read_valid, mem_write_valid, mem_read_address, mem_write_address);
        end
        mem_write_ready = 1'b1;
        step();
        mem_write_ready = 1'b0;
        checks++;
        if (lsu_state !== 2'b10 || mem_read_valid !== 1'b1) begin
            errors++; $display("FAIL stray_write_ready state %b rv %b want 10 1", lsu_state, mem_read_valid);
        end
        mem_read_ready = 1'b1; mem_read_data = 8'h12;
        step();
        mem_read_ready = 1'b0;
        checks++;
        if (lsu_state !== 2'b11 || lsu_out !== 8'h12) begin
            errors++; $display("FAIL priority_done state %b out %h want 11 12", lsu_state, lsu_out);
        end
        release_done();
    endtask

    task automatic test_reset_enable();
        start_access(1'b1, 1'b0, 8'h66, 8'h00);
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if (lsu_state !== 2'b00 || mem_read_valid !== 1'b0 || mem_read_address !== 8'h00 || lsu_out !== 8'h00) begin
            errors++; $display("FAIL midreset state %b rv %b addr %h out %h want 00 0 00 00", lsu_state, mem_read_valid, mem_read_address, lsu_out);
        end
        idle_inputs();
        mem_read_ready = 1'b1; mem_read_data = 8'h99;
        step();
        mem_read_ready = 1'b0;
        checks++;
        if (lsu_state !== 2'b00 || lsu_out !== 8'h00) begin
            errors++; $display("FAIL late_ready state %b out %h want 00 00", lsu_state, lsu_out);
        end
        start_access(1'b1, 1'b0, 8'h77, 8'h00);
        enable = 1'b0;
        mem_read_ready = 1'b1; mem_read_data = 8'hAA;
        step();
        step();
        checks++;
        if (lsu_state !== 2'b10 || mem_read_valid !== 1'b1 || mem_read_address !== 8'h77 || lsu_out !== 8'h00) begin
            errors++; $display("FAIL freeze state %b rv %b addr %h out %h want 10 1 77 00", lsu_state, mem_read_valid, mem_read_address, lsu_out);
        end
        enable = 1'b1;
        step();
        mem_read_ready = 1'b0;
        checks++;
        if (lsu_state !== 2'b11 || lsu_out !== 8'hAA || mem_read_valid !== 1'b0) begin
            errors++; $display("FAIL unfreeze state %b out %h rv %b want 11 aa 0", lsu_state, lsu_out, mem_read_valid);
        end
        release_done();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_priority();
        test_reset_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
